// File: rtl/mod_updown_counter_pkg.sv
// Shared constants and helpers for the prescaled up/down modulo counter.
// Direction encodings and default widths live here so top, interface and bench agree.
package mod_counter_pkg;

   localparam logic DIR_UP      = 1'b1;
   localparam logic DIR_DN      = 1'b0;
   localparam int   DEF_WIDTH   = 8;
   localparam int   DEF_PRESC_W = 4;

   // What the count register does in a given cycle, in priority order.
   typedef enum logic [1:0] {
      ACT_HOLD = 2'd0,
      ACT_LOAD = 2'd1,
      ACT_STEP = 2'd2
   } cnt_act_e;

endpackage : mod_counter_pkg

// File: rtl/mod_updown_counter_if.sv
// Control/status bundle of the up/down counter: driver-side (master) and counter-side (slave) views.
interface mod_updown_counter_if
   import mod_counter_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int PRESC_W = DEF_PRESC_W
);

   logic               en;
   logic               up_dn;
   logic               load;
   logic [WIDTH-1:0]   load_val;
   logic [WIDTH-1:0]   limit;
   logic [PRESC_W-1:0] presc;
   logic               clr_flags;
   logic [WIDTH-1:0]   count;
   logic               tc;
   logic               ovf;
   logic               unf;

   modport master (
      output en, up_dn, load, load_val, limit, presc, clr_flags,
      input  count, tc, ovf, unf
   );

   modport slave (
      input  en, up_dn, load, load_val, limit, presc, clr_flags,
      output count, tc, ovf, unf
   );

endinterface : mod_updown_counter_if

// File: rtl/mod_updown_counter_tick_prescaler.sv
// Enable-gated prescaler: emits a combinational tick on every (presc+1)-th enabled cycle.
// clr (driven by load) restarts the phase at 0 regardless of en.
module tick_prescaler
   import mod_counter_pkg::*;
#(
   parameter int PRESC_W = DEF_PRESC_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               clr,
   input  logic [PRESC_W-1:0] presc,
   output logic               tick
);

   logic [PRESC_W-1:0] phase_q;
   logic [PRESC_W-1:0] phase_d;

   // If presc is lowered below the current phase, the phase wraps through
   // zero and re-synchronises on its own.
   always_comb begin
      tick    = en && (phase_q == presc);
      phase_d = phase_q;
      if (clr) begin
         phase_d = '0;
      end else if (en) begin
         phase_d = tick ? '0 : phase_q + PRESC_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase_q <= '0;
      end else begin
         phase_q <= phase_d;
      end
   end

endmodule : tick_prescaler

// File: rtl/mod_updown_counter.sv
// Prescaled up/down modulo counter (0..limit) with registered tc pulse and sticky ovf/unf flags.
// Define COUNTER_SATURATE_EN to hold at the bounds instead of wrapping.
module mod_updown_counter
   import mod_counter_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int PRESC_W = DEF_PRESC_W
) (
   input  logic                 clk,
   input  logic                 reset,
   mod_updown_counter_if.slave  bus
);

   logic             tick;
   cnt_act_e         act;
   logic             at_top;
   logic             at_bot;
   logic             ovf_set;
   logic             unf_set;
   logic [WIDTH-1:0] load_clamped;

   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q,    tc_d;
   logic             ovf_q,   ovf_d;
   logic             unf_q,   unf_d;

   tick_prescaler #(
      .PRESC_W (PRESC_W)
   ) u_presc (
      .clk   (clk),
      .reset (reset),
      .en    (bus.en),
      .clr   (bus.load),
      .presc (bus.presc),
      .tick  (tick)
   );

   always_comb begin
      act = ACT_HOLD;
      if (bus.load) begin
         act = ACT_LOAD;
      end else if (tick) begin
         act = ACT_STEP;
      end
   end

   // >= rather than == so a limit lowered under the count still wraps on the next up tick.
   assign at_top       = (count_q >= bus.limit);
   assign at_bot       = (count_q == '0);
   assign load_clamped = (bus.load_val > bus.limit) ? bus.limit : bus.load_val;

   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      unique case (act)
         ACT_LOAD: begin
            count_d = load_clamped;
         end
         ACT_STEP: begin
            if (bus.up_dn == DIR_UP) begin
               if (at_top) begin
`ifdef COUNTER_SATURATE_EN
                  count_d = bus.limit;
`else
                  count_d = '0;
`endif
                  tc_d    = 1'b1;
                  ovf_set = 1'b1;
               end else begin
                  count_d = count_q + WIDTH'(1);
               end
            end else begin
               if (at_bot) begin
`ifdef COUNTER_SATURATE_EN
                  count_d = '0;
`else
                  count_d = bus.limit;
`endif
                  tc_d    = 1'b1;
                  unf_set = 1'b1;
               end else begin
                  count_d = count_q - WIDTH'(1);
               end
            end
         end
         default: begin
            count_d = count_q;
         end
      endcase
   end

   // A new set event in the same cycle as clr_flags wins.
   always_comb begin
      ovf_d = ovf_set | (ovf_q & ~bus.clr_flags);
      unf_d = unf_set | (unf_q & ~bus.clr_flags);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign bus.count = count_q;
   assign bus.tc    = tc_q;
   assign bus.ovf   = ovf_q;
   assign bus.unf   = unf_q;

endmodule : mod_updown_counter

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter at WIDTH=4, PRESC_W=4; expectations follow COUNTER_SATURATE_EN.
module tb_mod_updown_counter;
   import mod_counter_pkg::*;

   localparam int W = 4;
   localparam int P = 4;
`ifdef COUNTER_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;

   mod_updown_counter_if #(.WIDTH(W), .PRESC_W(P)) bus ();

   mod_updown_counter #(.WIDTH(W), .PRESC_W(P)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [3:0] c, input logic t,
                          input logic o, input logic u);
      chk({tag, ".count"}, 32'(bus.count), 32'(c));
      chk({tag, ".tc"},    32'(bus.tc),    32'(t));
      chk({tag, ".ovf"},   32'(bus.ovf),   32'(o));
      chk({tag, ".unf"},   32'(bus.unf),   32'(u));
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset         = 1'b1;
      bus.en        = 1'b0;
      bus.up_dn     = DIR_UP;
      bus.load      = 1'b0;
      bus.load_val  = '0;
      bus.limit     = '0;
      bus.presc     = '0;
      bus.clr_flags = 1'b0;
      #1 reset = 1'b0;
      #1 chk_out("rst_async", 4'd0, 1'b0, 1'b0, 1'b0);
      cyc(2);
      chk_out("rst_hold", 4'd0, 1'b0, 1'b0, 1'b0);

      // Full-range up count with presc=0
      bus.limit = 4'd15; bus.presc = '0; bus.up_dn = DIR_UP; bus.en = 1'b1;
      reset = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         cyc(1);
         chk_out($sformatf("t1_up%0d", i), i[3:0], 1'b0, 1'b0, 1'b0);
      end
      cyc(1); chk_out("t1_wrap", SAT ? 4'd15 : 4'd0, 1'b1, 1'b1, 1'b0);
      cyc(1); chk_out("t1_post", SAT ? 4'd15 : 4'd1, SAT, 1'b1, 1'b0);
      bus.en = 1'b0; bus.clr_flags = 1'b1;
      cyc(1); chk_out("t1_clr", SAT ? 4'd15 : 4'd1, 1'b0, 1'b0, 1'b0);
      bus.en = 1'b1; bus.clr_flags = 1'b0;

      // presc=2: one step every third cycle, then clamped load restarts the phase
      bus.load = 1'b1; bus.load_val = 4'd0; bus.limit = 4'd9; bus.presc = 4'd2;
      cyc(1); chk_out("t2_ld0", 4'd0, 1'b0, 1'b0, 1'b0);
      bus.load = 1'b0;
      for (int k = 0; k < 6; k++) begin
         cyc(1);
         chk($sformatf("t2_presc%0d", k), 32'(bus.count), 32'((k + 1) / 3));
      end
      cyc(1); chk("t2_ph1", 32'(bus.count), 32'd2);
      bus.load = 1'b1; bus.load_val = 4'd12;
      cyc(1); chk_out("t2_clamp", 4'd9, 1'b0, 1'b0, 1'b0);
      bus.load = 1'b0;
      cyc(1); chk("t2_restart1", 32'(bus.count), 32'd9);
      cyc(1); chk("t2_restart2", 32'(bus.count), 32'd9);
      cyc(1); chk_out("t2_wrap", SAT ? 4'd9 : 4'd0, 1'b1, 1'b1, 1'b0);
      bus.en = 1'b0; bus.clr_flags = 1'b1;
      cyc(1); chk_out("t2_clr", SAT ? 4'd9 : 4'd0, 1'b0, 1'b0, 1'b0);
      bus.en = 1'b1; bus.clr_flags = 1'b0;

      // Down wrap, then clear colliding with a new wrap
      bus.up_dn = DIR_DN; bus.limit = 4'd5; bus.presc = '0;
      bus.load = 1'b1; bus.load_val = 4'd1;
      cyc(1); chk_out("t3_ld1", 4'd1, 1'b0, 1'b0, 1'b0);
      bus.load = 1'b0;
      cyc(1); chk_out("t3_dec", 4'd0, 1'b0, 1'b0, 1'b0);
      cyc(1); chk_out("t3_wrap", SAT ? 4'd0 : 4'd5, 1'b1, 1'b0, 1'b1);
      cyc(1); chk_out("t3_post", SAT ? 4'd0 : 4'd4, SAT, 1'b0, 1'b1);
      bus.load = 1'b1; bus.load_val = 4'd0;
      cyc(1); chk_out("t3_ld0", 4'd0, 1'b0, 1'b0, 1'b1);
      bus.load = 1'b0; bus.clr_flags = 1'b1;
      cyc(1); chk_out("t3_clr_vs_set", SAT ? 4'd0 : 4'd5, 1'b1, 1'b0, 1'b1);
      bus.en = 1'b0;
      cyc(1); chk_out("t3_clr_hold", SAT ? 4'd0 : 4'd5, 1'b0, 1'b0, 1'b0);
      bus.en = 1'b1; bus.clr_flags = 1'b0;

      // Limit lowered under count: up wraps, down decrements
      bus.up_dn = DIR_UP; bus.limit = 4'd15; bus.load = 1'b1; bus.load_val = 4'd8;
      cyc(1); chk("t4_ld8", 32'(bus.count), 32'd8);
      bus.load = 1'b0; bus.limit = 4'd3;
      cyc(1); chk_out("t4_up_low", SAT ? 4'd3 : 4'd0, 1'b1, 1'b1, 1'b0);
      bus.up_dn = DIR_DN; bus.limit = 4'd15; bus.load = 1'b1;
      cyc(1); chk_out("t4_ld8b", 4'd8, 1'b0, 1'b1, 1'b0);
      bus.load = 1'b0; bus.limit = 4'd3;
      cyc(1); chk_out("t4_dn_low", 4'd7, 1'b0, 1'b1, 1'b0);
      bus.en = 1'b0; bus.clr_flags = 1'b1;
      cyc(1); chk_out("t4_clr", 4'd7, 1'b0, 1'b0, 1'b0);
      bus.en = 1'b1; bus.clr_flags = 1'b0;

      // Direction change mid-phase: no extra latency, phase kept
      bus.up_dn = DIR_UP; bus.limit = 4'd15; bus.presc = 4'd1;
      bus.load = 1'b1; bus.load_val = 4'd5;
      cyc(1); chk("t5_ld5", 32'(bus.count), 32'd5);
      bus.load = 1'b0;
      cyc(1); chk("t5_ph1", 32'(bus.count), 32'd5);
      cyc(1); chk("t5_up", 32'(bus.count), 32'd6);
      cyc(1); chk("t5_ph1b", 32'(bus.count), 32'd6);
      bus.up_dn = DIR_DN;
      cyc(1); chk("t5_dn", 32'(bus.count), 32'd5);

      // Async reset mid-phase (presc=3, phase=2)
      bus.up_dn = DIR_UP; bus.presc = 4'd3; bus.load = 1'b1; bus.load_val = 4'd5;
      cyc(1); chk("t6_ld5", 32'(bus.count), 32'd5);
      bus.load = 1'b0;
      cyc(2); chk("t6_ph2", 32'(bus.count), 32'd5);
      #2 reset = 1'b0;
      #1 chk_out("t6_async", 4'd0, 1'b0, 1'b0, 1'b0);
      cyc(1); chk("t6_inrst", 32'(bus.count), 32'd0);
      reset = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         cyc(1);
         chk($sformatf("t6_wait%0d", k), 32'(bus.count), 32'd0);
      end
      cyc(1); chk("t6_first", 32'(bus.count), 32'd1);

      // limit=0: continuous wrap, tc stays high; en=0 drops tc and holds
      bus.limit = 4'd0; bus.presc = '0; bus.load = 1'b1; bus.load_val = 4'd0;
      cyc(1); chk_out("t7_ld0", 4'd0, 1'b0, 1'b0, 1'b0);
      bus.load = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc(1);
         chk_out($sformatf("t7_lim0_%0d", k), 4'd0, 1'b1, 1'b1, 1'b0);
      end
      bus.en = 1'b0;
      cyc(1); chk_out("t7_en0", 4'd0, 1'b0, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_mod_updown_counter
